// File: rtl/shift_pkg.sv
// Shared constants and FSM encoding for the shifter / unshifter datapath.
package shift_pkg;

  localparam int SHIFT_IN_W  = 5;
  localparam int SHIFT_OUT_W = 4;
  localparam int SHIFT_AMT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/rshift_stage.sv
// One-bit logical right-shift stage: each bit selects between hold and its left neighbour.
module rshift_stage #(
  parameter int W = 5
) (
  input  logic [W-1:0] data,
  input  logic         en,
  output logic [W-1:0] shifted,
  output logic         shifted_out
);

  assign shifted[W-1] = en ? 1'b0 : data[W-1];

  for (genvar i = 0; i < W - 1; i++) begin : g_bit
    assign shifted[i] = en ? data[i+1] : data[i];
  end

  assign shifted_out = data[0];

endmodule

// File: rtl/serial_unshifter.sv
// Serial right-shifter that undoes a left shift one bit per clock, flagging lost bits and overflow.
module serial_unshifter
  import shift_pkg::*;
#(
  parameter int IN_W  = SHIFT_IN_W,
  parameter int OUT_W = SHIFT_OUT_W,
  parameter int AMT_W = SHIFT_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  y,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] w,
  output logic             lost,
  output logic             ovf
);

  state_t            state, state_next;
  logic [IN_W-1:0]   data, data_shifted;
  logic [AMT_W-1:0]  cnt;
  logic              lost_q;
  logic              load, shift_en, shifted_out;

  rshift_stage #(.W(IN_W)) u_stage (
    .data        (data),
    .en          (shift_en),
    .shifted     (data_shifted),
    .shifted_out (shifted_out)
  );

  assign in_ready = rst_n & (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      // amt==0 spends one hold cycle here so every amount has at least one cycle of latency.
      SHIFT: begin
        shift_en = (cnt != '0);
        if (cnt <= AMT_W'(1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the datapath registers are reset too, since w/ovf are decoded straight from them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data   <= '0;
      cnt    <= '0;
      lost_q <= 1'b0;
    end else if (load) begin
      data   <= y;
      cnt    <= amt;
      lost_q <= 1'b0;
    end else if (shift_en) begin
      data   <= data_shifted;
      cnt    <= cnt - AMT_W'(1);
      lost_q <= lost_q | shifted_out;
    end
  end

  assign out_valid = (state == DONE);
  assign w         = data[OUT_W-1:0];
  assign lost      = lost_q;
  assign ovf       = |data[IN_W-1:OUT_W];

endmodule
